// File: rtl/odd_parity_tx_pkg.sv
//============================================================================
// Module  : odd_parity_tx_pkg
// Brief   : Shared FSM states, line levels and parity helper for the
//           odd-parity serial transmitter.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package odd_parity_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Callers zero-extend into this width; zero padding leaves the XOR unchanged.
    localparam int MAX_DATA_W = 64;

    function automatic logic odd_parity(input logic [MAX_DATA_W-1:0] data);
        return ~^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/odd_parity_serial_tx_if.sv
//============================================================================
// Module  : odd_parity_serial_tx_if
// Brief   : Upstream valid/ready word handshake. Carries err_inject when
//           ODD_PARITY_TX_ERR_INJECT_EN is defined.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

interface odd_parity_serial_tx_if #(
    parameter int DATA_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
    logic              err_inject;

    modport master (output in_valid, output in_data, output err_inject, input in_ready);
    modport slave  (input in_valid, input in_data, input err_inject, output in_ready);
`else
    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
`endif
endinterface

`default_nettype wire

// File: rtl/parity_bit_timer.sv
//============================================================================
// Module  : parity_bit_timer
// Brief   : Per-bit divide counter; bit_end_o marks the last cycle of a bit.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module parity_bit_timer #(
    parameter int DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clear_i,
    input  wire logic run_i,
    output logic      bit_end_o
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("parity_bit_timer: DIV must be >= 1");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // With DIV=1 LAST_CNT is 0, so every running cycle is a bit end.
    assign bit_end_o = run_i && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !run_i || bit_end_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/odd_parity_serial_tx.sv
//============================================================================
// Module  : odd_parity_serial_tx
// Brief   : Serialises start/data(LSB first)/odd-parity/stop frames and
//           presents the latched word and parity in parallel.
//           Optional: ODD_PARITY_TX_ERR_INJECT_EN (inverts parity per frame).
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module odd_parity_serial_tx
    import odd_parity_tx_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int DIV    = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    odd_parity_serial_tx_if.slave   up_if,
    output logic                    tx_serial_o,
    output logic                    tx_busy_o,
    output logic [DATA_W-1:0]       frame_data_o,
    output logic                    frame_parity_o,
    output logic                    frame_done_o
);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    generate
        if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
            $error("odd_parity_serial_tx: DATA_W must be in 1..MAX_DATA_W");
        end
        if (DIV < 1) begin : g_bad_div
            $error("odd_parity_serial_tx: DIV must be >= 1");
        end
    endgenerate

    tx_state_e         state_q,        state_d;
    logic [BIT_W-1:0]  bit_q,          bit_d;
    logic [DATA_W-1:0] frame_data_q,   frame_data_d;
    logic              frame_parity_q, frame_parity_d;
    logic              tx_serial_q,    tx_serial_d;
    logic              in_ready_q,     in_ready_d;
    logic              tx_busy_q,      tx_busy_d;
    logic              frame_done_q,   frame_done_d;

    logic w_accept;
    logic w_bit_end;
    logic w_new_parity;

    assign w_accept = up_if.in_valid && in_ready_q;

`ifdef ODD_PARITY_TX_ERR_INJECT_EN
    assign w_new_parity = odd_parity(MAX_DATA_W'(up_if.in_data)) ^ up_if.err_inject;
`else
    assign w_new_parity = odd_parity(MAX_DATA_W'(up_if.in_data));
`endif

    parity_bit_timer #(
        .DIV (DIV)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (w_accept),
        .run_i     (state_q != IDLE),
        .bit_end_o (w_bit_end)
    );

    always_comb begin
        state_d        = state_q;
        bit_d          = bit_q;
        frame_data_d   = frame_data_q;
        frame_parity_d = frame_parity_q;
        tx_serial_d    = LINE_IDLE;

        unique case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d        = START;
                    frame_data_d   = up_if.in_data;
                    frame_parity_d = w_new_parity;
                end
            end
            START: begin
                if (w_bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = PARITY;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) state_d = STOP;
            end
            STOP: begin
                if (w_bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so the line level is decoded from the next state.
        unique case (state_d)
            START:   tx_serial_d = START_BIT;
            DATA:    tx_serial_d = frame_data_d[bit_d];
            PARITY:  tx_serial_d = frame_parity_d;
            STOP:    tx_serial_d = STOP_BIT;
            default: tx_serial_d = LINE_IDLE;
        endcase

        in_ready_d   = (state_d == IDLE);
        tx_busy_d    = (state_d != IDLE);
        frame_done_d = (state_q == STOP) && w_bit_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_q          <= '0;
            frame_data_q   <= '0;
            frame_parity_q <= 1'b1;
            tx_serial_q    <= LINE_IDLE;
            in_ready_q     <= 1'b0;
            tx_busy_q      <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_q          <= bit_d;
            frame_data_q   <= frame_data_d;
            frame_parity_q <= frame_parity_d;
            tx_serial_q    <= tx_serial_d;
            in_ready_q     <= in_ready_d;
            tx_busy_q      <= tx_busy_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign up_if.in_ready = in_ready_q;
    assign tx_serial_o    = tx_serial_q;
    assign tx_busy_o      = tx_busy_q;
    assign frame_data_o   = frame_data_q;
    assign frame_parity_o = frame_parity_q;
    assign frame_done_o   = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_odd_parity_serial_tx.sv
//============================================================================
// Module  : tb_odd_parity_serial_tx
// Brief   : Directed bench for odd_parity_serial_tx at DIV=1 and DIV=4.
//           Honours ODD_PARITY_TX_ERR_INJECT_EN when defined.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_odd_parity_serial_tx;

    logic clk;
    logic rst_n;

    odd_parity_serial_tx_if #(.DATA_W(3)) intf1 ();
    odd_parity_serial_tx_if #(.DATA_W(3)) intf4 ();

    logic       ser1, busy1, fp1, done1;
    logic [2:0] fd1;
    logic       ser4, busy4, fp4, done4;
    logic [2:0] fd4;

    odd_parity_serial_tx #(.DATA_W(3), .DIV(1)) u_dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .up_if          (intf1),
        .tx_serial_o    (ser1),
        .tx_busy_o      (busy1),
        .frame_data_o   (fd1),
        .frame_parity_o (fp1),
        .frame_done_o   (done1)
    );

    odd_parity_serial_tx #(.DATA_W(3), .DIV(4)) u_dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .up_if          (intf4),
        .tx_serial_o    (ser4),
        .tx_busy_o      (busy4),
        .frame_data_o   (fd4),
        .frame_parity_o (fp4),
        .frame_done_o   (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Accept d on the DIV=1 unit and check the whole frame; returns in the first idle cycle.
    task automatic frame1(input string tag, input logic [2:0] d, input logic [2:0] d_next,
                          input logic hold_valid, input logic p_exp);
        logic [5:0] ex;
        intf1.in_valid = 1'b1;
        intf1.in_data  = d;
        step();
        intf1.in_valid = hold_valid;
        intf1.in_data  = d_next;
        ex = {1'b0, d[0], d[1], d[2], p_exp, 1'b1};
        for (int i = 0; i < 6; i++) begin
            chk1($sformatf("%s_ser%0d", tag, i), ser1, ex[5]);
            chk1($sformatf("%s_busy%0d", tag, i), busy1, 1'b1);
            chk1($sformatf("%s_rdy%0d", tag, i), intf1.in_ready, 1'b0);
            chk1($sformatf("%s_done%0d", tag, i), done1, 1'b0);
            chk3($sformatf("%s_fd%0d", tag, i), fd1, d);
            chk1($sformatf("%s_fp%0d", tag, i), fp1, p_exp);
            ex = ex << 1;
            step();
        end
        chk1({tag, "_done_end"}, done1, 1'b1);
        chk1({tag, "_rdy_end"}, intf1.in_ready, 1'b1);
        chk1({tag, "_busy_end"}, busy1, 1'b0);
        chk1({tag, "_ser_idle"}, ser1, 1'b1);
    endtask

    logic [5:0] ex4;
    logic       z;

    initial begin
        rst_n          = 1'b0;
        intf1.in_valid = 1'b0;
        intf1.in_data  = 3'b000;
        intf4.in_valid = 1'b0;
        intf4.in_data  = 3'b000;
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
        intf1.err_inject = 1'b0;
        intf4.err_inject = 1'b0;
`endif

        // Reset state
        intf1.in_valid = 1'b1;
        step();
        step();
        chk1("rst_rdy", intf1.in_ready, 1'b0);
        chk1("rst_ser", ser1, 1'b1);
        chk1("rst_fp", fp1, 1'b1);
        chk1("rst_busy", busy1, 1'b0);
        chk1("rst_done", done1, 1'b0);
        chk3("rst_fd", fd1, 3'b000);
        intf1.in_valid = 1'b0;

        rst_n = 1'b1;
        step();
        chk1("rel_rdy1", intf1.in_ready, 1'b1);
        chk1("rel_rdy4", intf4.in_ready, 1'b1);
        chk1("rel_ser", ser1, 1'b1);
        chk1("rel_busy", busy1, 1'b0);

        // All-zero word, DIV=1
        frame1("f000", 3'b000, 3'b000, 1'b0, 1'b1);
        step();
        chk1("f000_done_pulse", done1, 1'b0);
        chk1("f000_rdy_hold", intf1.in_ready, 1'b1);

        // Back-to-back with in_valid held; in_data changes mid-frame
        frame1("f101", 3'b101, 3'b111, 1'b1, 1'b1);
        frame1("f111", 3'b111, 3'b111, 1'b0, 1'b0);
        step();
        chk1("f111_done_pulse", done1, 1'b0);
        chk3("f111_fd_hold", fd1, 3'b111);

        // DIV=4 word 3'b011: 24-cycle frame
        intf4.in_valid = 1'b1;
        intf4.in_data  = 3'b011;
        step();
        intf4.in_valid = 1'b0;
        intf4.in_data  = 3'b100;
        ex4 = 6'b011011;
        for (int i = 0; i < 24; i++) begin
            chk1($sformatf("d4_ser%0d", i), ser4, ex4[5]);
            chk1($sformatf("d4_busy%0d", i), busy4, 1'b1);
            chk1($sformatf("d4_done%0d", i), done4, 1'b0);
            chk1($sformatf("d4_fp%0d", i), fp4, 1'b1);
            chk3($sformatf("d4_fd%0d", i), fd4, 3'b011);
            if ((i % 4) == 3) ex4 = ex4 << 1;
            step();
        end
        chk1("d4_done_end", done4, 1'b1);
        chk1("d4_busy_end", busy4, 1'b0);
        chk1("d4_rdy_end", intf4.in_ready, 1'b1);
        chk1("d4_ser_idle", ser4, 1'b1);
        step();
        chk1("d4_done_pulse", done4, 1'b0);

        // Reset during DATA aborts the frame asynchronously
        intf1.in_valid = 1'b1;
        intf1.in_data  = 3'b101;
        step();
        intf1.in_valid = 1'b0;
        step();
        step();
        chk1("ab_mid_ser", ser1, 1'b0);
        chk1("ab_mid_busy", busy1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("ab_async_ser", ser1, 1'b1);
        chk1("ab_async_busy", busy1, 1'b0);
        chk1("ab_async_rdy", intf1.in_ready, 1'b0);
        chk3("ab_async_fd", fd1, 3'b000);
        chk1("ab_async_fp", fp1, 1'b1);
        step();
        chk1("ab_done0", done1, 1'b0);
        step();
        chk1("ab_done1", done1, 1'b0);
        rst_n = 1'b1;
        step();
        chk1("ab_rel_rdy", intf1.in_ready, 1'b1);
        chk1("ab_rel_done", done1, 1'b0);
        frame1("f100", 3'b100, 3'b000, 1'b0, 1'b0);

`ifdef ODD_PARITY_TX_ERR_INJECT_EN
        // Deliberate parity error, then a clean frame
        step();
        intf1.err_inject = 1'b1;
        frame1("ei1", 3'b000, 3'b000, 1'b0, 1'b0);
        z = ^{fp1, fd1};
        chk1("ei1_z", z, 1'b0);
        intf1.err_inject = 1'b0;
        frame1("ei0", 3'b000, 3'b000, 1'b0, 1'b1);
        z = ^{fp1, fd1};
        chk1("ei0_z", z, 1'b1);
`else
        z = ^{fp1, fd1};
        chk1("f100_z", z, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/odd_parity_serial_tx.md
Name: odd_parity_serial_tx

Overview:
- Upstream stage of the odd-parity checker. Accepts a parallel data word over a valid/ready handshake and computes its odd-parity bit.
- Transmits a serial frame: start, data LSB-first, parity, stop.
- Also presents the latched word and parity bit in parallel, so the downstream parity detector (p, a, b, c inputs) can be driven directly.
- Odd parity: the total count of ones across the data bits and the parity bit is odd.

Parameters:
DATA_W, 3, data bits per frame (>=1; 3 matches the downstream detector)
DIV, 4, clock cycles per serial bit (>=1)

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word
in_data  input  DATA_W  word to send
tx_serial  output  1  serial line, idles high
tx_busy  output  1  frame in progress
frame_data  output  DATA_W  last accepted word (to detector a/b/c)
frame_parity  output  1  odd-parity bit of frame_data (to detector p)
frame_done  output  1  one-cycle pulse at end of frame

Behaviour:
- One clock. Reset is asynchronous and active-low.
- All outputs are registered.
- Reset values: in_ready=0, tx_serial=1, tx_busy=0, frame_data=0, frame_parity=1 (odd-valid for all-zero data), frame_done=0, state=IDLE, counters=0.
- First clock after rst_n deasserts: in_ready goes to 1.
- Accept: in_valid & in_ready at a rising edge. On that edge:
  - frame_data <= in_data; frame_parity <= ~^in_data.
  - in_ready <= 0, tx_busy <= 1, state -> START.
- in_data is ignored when no accept occurs. in_valid may be held high; only one word is taken per accept.
- FSM IDLE -> START -> DATA -> PARITY -> STOP -> IDLE. Each state drives tx_serial for exactly DIV cycles:
  - START: tx_serial=0.
  - DATA: bit k = frame_data[k], k=0..DATA_W-1. A bit counter advances every DIV cycles; leave DATA after bit DATA_W-1.
  - PARITY: tx_serial=frame_parity.
  - STOP: tx_serial=1.
- Frame length: (DATA_W+3)*DIV cycles, from the cycle after accept to the last STOP cycle inclusive.
- End of frame: the edge ending the last STOP cycle sets state=IDLE, in_ready=1, tx_busy=0 and frame_done=1 for one cycle.
- Back-to-back frames: an accept in that first IDLE cycle starts the next start bit on the following cycle. Minimum frame-to-frame gap is 1 idle-high cycle.
- frame_data and frame_parity hold until the next accept. They never change mid-frame.
- DIV=1: the divide counter degenerates and every state lasts exactly one cycle. Counter width is max(1, $clog2(DIV)).
- Reset mid-frame aborts immediately: tx_serial=1 asynchronously, partial frame discarded, no frame_done.
- Elaboration error if DATA_W<1 or DIV<1.

Optional Feature:
- Macro: ODD_PARITY_TX_ERR_INJECT_EN.
- Defined: adds input port err_inject (1 bit), sampled only on accept. When 1, frame_parity and the serial parity bit are inverted for that frame, producing a deliberate parity error for the downstream detector (z=0).
- Undefined: port absent; parity is always correct.

Decomposition:
- Package odd_parity_tx_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1;
  - function odd_parity(data) returning ~^data.
- One sub-module, parity_bit_timer: DIV counter, emits a bit_end pulse on the last cycle of each bit, cleared on accept and on reset.

Test Plan:
- Reset release, DATA_W=3, DIV=1 -> in_ready=0 during reset, 1 on first cycle after; tx_serial=1, frame_parity=1.
- Accept in_data=3'b000, DIV=1 -> tx_serial sequence 0,0,0,0,1,1; frame_parity=1; frame_done pulses 6 cycles after accept.
- Accept 3'b101, then 3'b111 back-to-back (in_valid held) -> parity 1 then 0; serial 0,1,0,1,1,1 then 0,1,1,1,0,1; one idle cycle between frames.
- DIV=4, accept 3'b011 -> each bit held 4 cycles; 24-cycle frame; tx_busy high throughout; parity=1.
- rst_n low during the DATA state -> tx_serial=1 without waiting for a clock; no frame_done; next accept after release sends a full correct frame.
- With ODD_PARITY_TX_ERR_INJECT_EN, err_inject=1 on accept of 3'b000 -> parity bit 0; downstream detector output z=0. The next frame with err_inject=0 gives z=1.
